// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - debounced pushbutton loads switches and shifts them out MSB-first on x
module pattern_serializer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_n,
    input  logic [WIDTH-1:0] sw,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic             key_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int CW = $clog2(WIDTH);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic             sync1;
    logic             sync2;
    logic [DW-1:0]    db_cnt;
    logic             differ;
    logic             db_flip;
    logic             press;
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    // The synchronized sample disagrees with the debounced level; enough of
    // those in a row flips the level, and a 0->1 flip is a press event.
    assign differ  = (~sync2) != key_level;
    assign db_flip = differ && (db_cnt == DB_LAST);
    assign press   = db_flip && !key_level;

    // x is the MSB of the shift register, which is zero whenever idle.
    assign x = shreg[WIDTH-1];

    // Two-flop synchronizer for the asynchronous, active-low pushbutton.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            key_level <= 1'b0;
        end else if (!differ) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            db_cnt    <= '0;
            key_level <= ~key_level;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    // Load on a press while idle, then shift one bit per clock and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        shreg <= sw;
                        cnt   <= CNT_LAST;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        shreg <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        cnt   <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - randomized and directed checks of pattern_serializer against a reference model
module tb_pattern_serializer;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_n = 1'b1;
    logic [W-1:0] sw = '0;
    logic         x;
    logic         busy;
    logic         done;
    logic         key_level;

    pattern_serializer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .sw        (sw),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .key_level (key_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: a two-deep delay line for the synchronizer,
    // the history of pressed samples seen since the last level change,
    // and the edge index of the most recent load.
    bit           sync_q[$];
    bit           hist[$];
    bit           m_level  = 1'b0;
    int           edge_n   = 0;
    int           load_at  = -1000;
    logic [W-1:0] m_pat    = '0;
    bit           exp_x    = 1'b0;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;

    bit prev_busy = 1'b0;
    int loads     = 0;
    int dones     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge(input bit r, input bit k, input logic [W-1:0] s_in);
        bit s;
        bit all_diff;
        int age;
        edge_n++;
        if (r) begin
            sync_q  = '{1'b1, 1'b1};
            hist.delete();
            m_level = 1'b0;
            load_at = -1000;
            m_pat   = '0;
        end else begin
            age = edge_n - load_at;
            s = sync_q.pop_front();
            sync_q.push_back(k);
            hist.push_back(!s);
            if (hist.size() > D) void'(hist.pop_front());
            all_diff = (hist.size() >= D);
            for (int i = 0; i < D; i++)
                if (all_diff && hist[hist.size()-1-i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = !m_level;
                hist.delete();
                if (m_level && !(age >= 1 && age <= W)) begin
                    load_at = edge_n;
                    m_pat   = s_in;
                end
            end
        end
        age = edge_n - load_at;
        exp_busy = (age >= 0) && (age < W);
        exp_x    = 1'b0;
        if (exp_busy) exp_x = m_pat[W-1-age];
        exp_done = (age == W);
    endtask

    task automatic tick(input bit r, input bit k);
        rst   = r;
        key_n = k;
        @(posedge clk);
        model_edge(r, k, sw);
        #1;
        check("x", 32'(x), 32'(exp_x));
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("key_level", 32'(key_level), 32'(m_level));
        if (busy && !prev_busy) loads++;
        if (done) dones++;
        prev_busy = busy;
    endtask

    // Hold the key pressed until a load, then record the serial stream.
    task automatic capture(output logic [W-1:0] got, output int nb);
        got = '0;
        nb  = 0;
        for (int i = 0; i < 40 && !busy; i++) tick(1'b0, 1'b0);
        while (busy && nb < 40) begin
            got = {got[W-2:0], x};
            nb++;
            tick(1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] pat_a;
        logic [W-1:0] pat_b;
        int           nb;
        int           lat;
        bit           busy_at;
        int           base;
        int           falls_exp;
        int           falls_got;
        bit           k;
        int           run;

        // Reset with the key held, then release reset: level rises 2+D edges later.
        repeat (3) tick(1'b1, 1'b0);
        check("reset_x", 32'(x), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        lat = 0;
        busy_at = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0);
            if (key_level && lat == 0) begin
                lat = i;
                busy_at = busy;
            end
        end
        check("press_latency", 32'(lat), 32'(D + 2));
        check("busy_with_level", 32'(busy_at), 1);
        repeat (12) tick(1'b0, 1'b1);

        // Directed pattern with full stream and done pulse.
        sw = 10'b1011001110;
        capture(got, nb);
        check("pattern", 32'(got), 32'(10'b1011001110));
        check("busy_cycles", 32'(nb), 32'(W));
        check("done_pulse", 32'(done), 1);
        tick(1'b0, 1'b0);
        check("done_clear", 32'(done), 0);
        check("idle_x", 32'(x), 0);
        repeat (10) tick(1'b0, 1'b1);

        // Glitch shorter than the debounce window is rejected.
        base = loads;
        repeat (D - 1) tick(1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1);
        check("glitch_level", 32'(key_level), 0);
        check("glitch_loads", 32'(loads - base), 0);

        // Re-press during the shift and a switch change are both ignored.
        pat_a = 10'h2B5;
        pat_b = 10'h14A;
        sw = pat_a;
        base = loads;
        for (int i = 0; i < 20 && !busy; i++) tick(1'b0, 1'b0);
        sw = pat_b;
        repeat (4) tick(1'b0, 1'b1);
        repeat (14) tick(1'b0, 1'b0);
        check("reload_ignored", 32'(loads - base), 1);
        repeat (10) tick(1'b0, 1'b1);
        capture(got, nb);
        check("new_pattern", 32'(got), 32'(pat_b));
        repeat (10) tick(1'b0, 1'b1);

        // Reset while bit 4 is on x aborts the pattern without done.
        sw = 10'h3FF;
        for (int i = 0; i < 20 && !busy; i++) tick(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        base = dones;
        tick(1'b1, 1'b0);
        check("abort_x", 32'(x), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        repeat (15) tick(1'b0, 1'b1);
        check("abort_no_done", 32'(dones - base), 0);

        // Stream for the downstream detector: count 1->0 transitions on x.
        sw = 10'b1010000000;
        falls_exp = 0;
        for (int i = W - 1; i > 0; i--)
            if (sw[i] && !sw[i-1]) falls_exp++;
        capture(got, nb);
        falls_got = 0;
        for (int i = W - 1; i > 0; i--)
            if (got[i] && !got[i-1]) falls_got++;
        check("detector_falls", 32'(falls_got), 32'(falls_exp));
        check("detector_falls_two", 32'(falls_got), 2);
        repeat (10) tick(1'b0, 1'b1);

        // Randomized key activity, switch changes and occasional resets.
        k = 1'b1;
        for (int n = 0; n < 400; n++) begin
            k   = $urandom_range(1, 0) != 0;
            run = $urandom_range(9, 1);
            if ($urandom_range(15, 0) == 0) sw = W'($urandom);
            for (int j = 0; j < run; j++) tick($urandom_range(199, 0) == 0, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
